// File: rtl/ifq_pkg.sv
// Shared types and helpers for the instruction fetch queue write side.
// Fetch FSM states, line geometry, and the line-alignment function.
package ifq_pkg;

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DROP
    } fetch_state_t;

    localparam int LINE_BYTES       = 16;
    localparam int LINE_OFFSET_BITS = 4;

    function automatic logic [63:0] line_align(
        input logic [63:0] a
    );
        return {a[63:LINE_OFFSET_BITS],
                {LINE_OFFSET_BITS{1'b0}}};
    endfunction

endpackage

// File: rtl/ifq_fetch_perf_cnt.sv
// Saturating performance counters for the line fetcher.
// Ports: clk/reset, three increment strobes, three 32-bit counts.
module ifq_fetch_perf_cnt (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        inc_lines_i,
    input  logic        inc_redir_i,
    input  logic        inc_stall_i,
    output logic [31:0] lines_o,
    output logic [31:0] redirects_o,
    output logic [31:0] stalls_o
);

    logic [31:0] lines_q, redir_q, stall_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lines_q <= '0;
            redir_q <= '0;
            stall_q <= '0;
        end else begin
            if (inc_lines_i && lines_q != '1)
                lines_q <= lines_q + 32'd1;
            if (inc_redir_i && redir_q != '1)
                redir_q <= redir_q + 32'd1;
            if (inc_stall_i && stall_q != '1)
                stall_q <= stall_q + 32'd1;
        end
    end

    assign lines_o     = lines_q;
    assign redirects_o = redir_q;
    assign stalls_o    = stall_q;

endmodule

// File: rtl/ifq_line_fetcher.sv
// Fetch-queue producer: requests lines, buffers responses, pushes them.
// Ports: icache req/rsp, queue write, flush redirect, debug fetch addr.
// Define IFQ_FETCH_PERF_EN to add o_perf_lines/redirects/stalls.
module ifq_line_fetcher
    import ifq_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 128,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = 32'h0040_0000
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    output logic                  req_valid,
    output logic [ADDR_WIDTH-1:0] req_addr,
    input  logic                  req_ready,
    input  logic                  rsp_valid,
    input  logic [LINE_WIDTH-1:0] rsp_data,
    output logic                  q_wr_en,
    output logic [LINE_WIDTH-1:0] q_wr_data,
    input  logic                  q_full,
    input  logic                  flush,
    input  logic [ADDR_WIDTH-1:0] jmp_branch_address,
`ifdef IFQ_FETCH_PERF_EN
    output logic [31:0]           o_perf_lines,
    output logic [31:0]           o_perf_redirects,
    output logic [31:0]           o_perf_stalls,
`endif
    output logic [ADDR_WIDTH-1:0] o_fetch_addr
);

    fetch_state_t          state_q, state_d;
    logic [ADDR_WIDTH-1:0] fetch_q, fetch_d;
    logic [LINE_WIDTH-1:0] line_q, line_d;
    logic [ADDR_WIDTH-1:0] tgt_addr;
    logic                  push;

    assign tgt_addr = ADDR_WIDTH'(
        line_align(64'(jmp_branch_address)));

    always_comb begin
        state_d = state_q;
        fetch_d = fetch_q;
        line_d  = line_q;
        push    = 1'b0;
        unique case (state_q)
            S_REQ: begin
                if (req_ready)
                    state_d = S_WAIT;
            end
            S_WAIT: begin
                if (rsp_valid) begin
                    line_d  = rsp_data;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (!q_full) begin
                    push    = 1'b1;
                    fetch_d = fetch_q +
                        ADDR_WIDTH'(LINE_BYTES);
                    state_d = S_REQ;
                end
            end
            S_DROP: begin
                if (rsp_valid)
                    state_d = S_REQ;
            end
            default: state_d = S_REQ;
        endcase
        // A redirect overrides everything; an accepted but
        // unanswered request leaves a stale response to drain.
        if (flush) begin
            push    = 1'b0;
            fetch_d = tgt_addr;
            line_d  = line_q;
            unique case (state_q)
                S_REQ:
                    state_d = req_ready ? S_DROP : S_REQ;
                S_WAIT:
                    state_d = rsp_valid ? S_REQ : S_DROP;
                S_HOLD:
                    state_d = S_REQ;
                S_DROP:
                    state_d = rsp_valid ? S_REQ : S_DROP;
                default:
                    state_d = S_REQ;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_REQ;
            fetch_q <= RESET_PC;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            fetch_q <= fetch_d;
            line_q  <= line_d;
        end
    end

    assign req_valid    = (state_q == S_REQ);
    assign req_addr     = fetch_q;
    assign q_wr_en      = push;
    assign q_wr_data    = line_q;
    assign o_fetch_addr = fetch_q;

`ifdef IFQ_FETCH_PERF_EN
    ifq_fetch_perf_cnt u_perf (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .inc_lines_i (push),
        .inc_redir_i (flush),
        .inc_stall_i ((state_q == S_HOLD) && q_full),
        .lines_o     (o_perf_lines),
        .redirects_o (o_perf_redirects),
        .stalls_o    (o_perf_stalls)
    );
`endif

endmodule

// File: tb/tb_ifq_line_fetcher.sv
// Self-checking bench for ifq_line_fetcher.
// Bench-side icache plus transaction-level reference model.
module tb_ifq_line_fetcher;

    localparam logic [31:0] RPC = 32'h0040_0000;

    logic         i_clk, i_rst_n;
    logic         req_valid, req_ready;
    logic [31:0]  req_addr;
    logic         rsp_valid;
    logic [127:0] rsp_data;
    logic         q_wr_en, q_full, flush;
    logic [127:0] q_wr_data;
    logic [31:0]  jmp_branch_address, o_fetch_addr;
`ifdef IFQ_FETCH_PERF_EN
    logic [31:0]  perf_l, perf_r, perf_s;
`endif

    ifq_line_fetcher dut (
        .i_clk              (i_clk),
        .i_rst_n            (i_rst_n),
        .req_valid          (req_valid),
        .req_addr           (req_addr),
        .req_ready          (req_ready),
        .rsp_valid          (rsp_valid),
        .rsp_data           (rsp_data),
        .q_wr_en            (q_wr_en),
        .q_wr_data          (q_wr_data),
        .q_full             (q_full),
        .flush              (flush),
        .jmp_branch_address (jmp_branch_address),
`ifdef IFQ_FETCH_PERF_EN
        .o_perf_lines       (perf_l),
        .o_perf_redirects   (perf_r),
        .o_perf_stalls      (perf_s),
`endif
        .o_fetch_addr       (o_fetch_addr)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int tests = 0;
    int fails = 0;

    // Reference model: what the fetcher owes, in transaction terms.
    logic [31:0]  m_addr;
    logic [127:0] m_line;
    bit           m_out, m_held, m_stale;

    // Bench icache: one response per accepted request.
    bit           ic_busy;
    int           ic_cnt, ic_lat, serial;
    logic [127:0] ic_data;

    logic [31:0]  req_log[$];
    logic [127:0] push_log[$];

    function automatic logic [127:0] line_of(
        input logic [31:0] a, input int s);
        return {a, ~a, 32'(s), a ^ 32'hA5A5_5A5A};
    endfunction

    task automatic chk(input string tag,
                       input logic [127:0] obs,
                       input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h",
                   tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_addr  = RPC;
        m_line  = '0;
        m_out   = 0;
        m_held  = 0;
        m_stale = 0;
        ic_busy = 0;
        ic_cnt  = 0;
        serial  = 0;
        req_log.delete();
        push_log.delete();
    endtask

    task automatic idle_inputs();
        flush = 0;
        jmp_branch_address = '0;
        q_full = 0;
        req_ready = 0;
        rsp_valid = 0;
        rsp_data = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        i_rst_n = 0;
        repeat (2) @(negedge i_clk);
        model_reset();
        i_rst_n = 1;
    endtask

    // One cycle, entered and left at a falling edge.
    task automatic step(input bit fl, input logic [31:0] tgt,
                        input bit qf, input bit rdy);
        bit rv, exp_wr, idle, acc, busy_pend;
        flush = fl;
        jmp_branch_address = tgt;
        q_full = qf;
        req_ready = rdy;
        rv = ic_busy && (ic_cnt == 0);
        rsp_valid = rv;
        rsp_data = rv ? ic_data :
            {$urandom, $urandom, $urandom, $urandom};
        #1;
        idle = !(m_out || m_held || m_stale);
        exp_wr = m_held && !qf && !fl;
        chk("req_valid", req_valid, idle);
        if (idle) chk("req_addr", req_addr, m_addr);
        chk("fetch_addr", o_fetch_addr, m_addr);
        chk("q_wr_en", q_wr_en, exp_wr);
        if (exp_wr) chk("q_wr_data", q_wr_data, m_line);
        if (rv) chk("rsp_while_req", req_valid, 0);
        if (q_wr_en) push_log.push_back(q_wr_data);
        acc = req_valid && rdy;
        if (acc) req_log.push_back(req_addr);
        busy_pend = ic_busy && !rv;
        if (acc) chk("single_outstanding", busy_pend, 0);
        if (fl) begin
            m_stale = (m_stale && !rv) || (m_out && !rv) ||
                      (idle && rdy);
            m_out  = 0;
            m_held = 0;
            m_addr = {tgt[31:4], 4'h0};
        end else if (m_stale) begin
            if (rv) m_stale = 0;
        end else if (m_out) begin
            if (rv) begin
                m_out  = 0;
                m_held = 1;
                m_line = rsp_data;
            end
        end else if (m_held) begin
            if (exp_wr) begin
                m_held = 0;
                m_addr = m_addr + 32'd16;
            end
        end else if (rdy) begin
            m_out = 1;
        end
        if (rv) ic_busy = 0;
        else if (ic_busy) ic_cnt--;
        if (acc) begin
            serial++;
            ic_busy = 1;
            ic_cnt  = ic_lat - 1;
            ic_data = line_of(req_addr, serial);
        end
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    initial begin
        i_rst_n = 0;
        ic_lat = 2;
        idle_inputs();
        model_reset();
        @(negedge i_clk);
        #1;
        chk("rst_req_valid", req_valid, 1);
        chk("rst_req_addr", req_addr, RPC);
        chk("rst_q_wr_en", q_wr_en, 0);
        chk("rst_q_wr_data", q_wr_data, 0);
        @(negedge i_clk);

        // Sequential fetch, response two cycles after accept.
        do_reset();
        for (int i = 0; i < 60 && push_log.size() < 3; i++)
            step(0, 0, 0, 1);
        chk("seq_timeout", push_log.size() >= 3, 1);
        for (int i = 0; i < 3; i++) begin
            if (i < req_log.size())
                chk("seq_addr", req_log[i], RPC + 32'(16 * i));
            if (i < push_log.size())
                chk("seq_data", push_log[i],
                    line_of(RPC + 32'(16 * i), i + 1));
        end

        // Queue full holds the line.
        do_reset();
        for (int i = 0; i < 20 && !m_held; i++)
            step(0, 0, 0, 1);
        repeat (5) step(0, 0, 1, 1);
        chk("full_no_push", push_log.size(), 0);
        step(0, 0, 0, 1);
        chk("full_one_push", push_log.size(), 1);
        if (push_log.size() > 0)
            chk("full_data", push_log[0], line_of(RPC, 1));
        for (int i = 0; i < 5 && req_log.size() < 2; i++)
            step(0, 0, 0, 1);
        chk("full_next_addr", req_log.size() > 1 ?
            req_log[1] : 32'hx, RPC + 32'h10);

        // Flush while waiting: stale response dropped.
        do_reset();
        ic_lat = 4;
        for (int i = 0; i < 5 && !m_out; i++)
            step(0, 0, 0, 1);
        step(1, 32'h0040_1238, 0, 0);
        for (int i = 0; i < 40 && push_log.size() < 1; i++)
            step(0, 0, 0, 1);
        chk("fw_addr", req_log.size() > 1 ?
            req_log[1] : 32'hx, 32'h0040_1230);
        chk("fw_data", push_log.size() > 0 ? push_log[0] :
            128'hx, line_of(32'h0040_1230, 2));

        // Flush in the same cycle as req_ready.
        do_reset();
        ic_lat = 2;
        step(1, 32'h0050_0004, 0, 1);
        for (int i = 0; i < 40 && push_log.size() < 1; i++)
            step(0, 0, 0, 1);
        repeat (4) step(0, 0, 0, 0);
        chk("fr_pushes", push_log.size(), 1);
        chk("fr_addr", req_log.size() > 1 ?
            req_log[1] : 32'hx, 32'h0050_0000);
        chk("fr_data", push_log.size() > 0 ? push_log[0] :
            128'hx, line_of(32'h0050_0000, 2));

        // Flush while holding a line, queue not full.
        do_reset();
        ic_lat = 1;
        for (int i = 0; i < 10 && !m_held; i++)
            step(0, 0, 0, 1);
        step(1, 32'h0060_0010, 0, 0);
        step(0, 0, 0, 1);
        chk("fh_pushes", push_log.size(), 0);
        chk("fh_addr", req_log.size() > 1 ?
            req_log[1] : 32'hx, 32'h0060_0010);

        // Address wrap, then reset in the middle of a wait.
        do_reset();
        step(1, 32'hFFFF_FFF4, 0, 0);
        for (int i = 0; i < 20 && req_log.size() < 2; i++)
            step(0, 0, 0, 1);
        chk("wrap_a0", req_log.size() > 0 ?
            req_log[0] : 32'hx, 32'hFFFF_FFF0);
        chk("wrap_a1", req_log.size() > 1 ?
            req_log[1] : 32'hx, 32'h0000_0000);
        ic_lat = 4;
        for (int i = 0; i < 20 && !m_out; i++)
            step(0, 0, 0, 1);
        idle_inputs();
        #2 i_rst_n = 0;
        #1;
        chk("ar_req_valid", req_valid, 1);
        chk("ar_req_addr", req_addr, RPC);
        chk("ar_fetch_addr", o_fetch_addr, RPC);
        chk("ar_q_wr_en", q_wr_en, 0);
        @(negedge i_clk);
        model_reset();
        i_rst_n = 1;
        step(0, 0, 0, 1);
        chk("ar_first_req", req_log.size() > 0 ?
            req_log[0] : 32'hx, RPC);

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            ic_lat = $urandom_range(1, 4);
            step(($urandom_range(0, 15) == 0),
                 $urandom,
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 1) == 1));
        end
`ifdef IFQ_FETCH_PERF_EN
        chk("perf_lines", perf_l, 32'(push_log.size()));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
